// File: rtl/multi_domain_reset_seq.sv
// Reset sequencer: waits for init, bank supply and PLL lock, then releases the
// fabric reset domains one by one; any fault drops every domain and recovers via HOLD.
module multi_domain_reset_seq #(
  parameter int N_OUT       = 4,
  parameter int N_LOCK      = 2,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILT   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              EXT_RST_N,
  input  logic              INIT_DONE,
  input  logic              BANK_VDDI_STATUS,
  input  logic [N_LOCK-1:0] PLL_LOCK,
  input  logic              SW_RST_REQ,
  output logic [N_OUT-1:0]  FABRIC_RESET_N,
  output logic              PLL_POWERDOWN_B,
  output logic              SEQ_DONE,
  output logic [2:0]        STATE
);

  localparam int REL_CYC = STAGE_DLY * N_OUT;
  localparam int MAX_CNT = (REL_CYC > LOCK_FILT) ? REL_CYC : LOCK_FILT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SYNC_W  = N_LOCK + 2;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  logic [SYNC_W-1:0] sync_p [SYNC_STAGES];
  logic              init_s;
  logic              bank_s;
  logic [N_LOCK-1:0] lock_s;
  logic              supply_ok;
  logic              all_lock;
  logic              fault;

  state_t            state_q;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [N_OUT-1:0]  fab_q;
  logic [N_OUT-1:0]  fab_nxt;
  logic              seq_q;
  logic              pll_q;

  // Synchronizer stages: INIT_DONE in bit 0, BANK_VDDI_STATUS in bit 1, locks above.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= {PLL_LOCK, BANK_VDDI_STATUS, INIT_DONE};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign init_s    = sync_p[SYNC_STAGES-1][0];
  assign bank_s    = sync_p[SYNC_STAGES-1][1];
  assign lock_s    = sync_p[SYNC_STAGES-1][SYNC_W-1:2];
  assign supply_ok = init_s & bank_s;
  assign all_lock  = &lock_s;
  assign fault     = ~all_lock | ~supply_ok | SW_RST_REQ;

  // Sequencer state and shared counter
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      fab_q   <= '0;
      seq_q   <= 1'b0;
      pll_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      fab_q   <= fab_nxt;
      seq_q   <= (state_nxt == ST_RUN);
      pll_q   <= (state_nxt != ST_RESET);
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    fab_nxt   = fab_q;
    cnt_inc   = cnt_q + 1'b1;
    case (state_q)
      ST_RESET: begin
        state_nxt = ST_WAIT_INIT;
        cnt_nxt   = '0;
        fab_nxt   = '0;
      end
      ST_WAIT_INIT: begin
        cnt_nxt = '0;
        fab_nxt = '0;
        if (supply_ok) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        fab_nxt = '0;
        if (!supply_ok) begin
          state_nxt = ST_WAIT_INIT;
          cnt_nxt   = '0;
        end else if (all_lock) begin
          if (cnt_inc == CNT_W'(LOCK_FILT)) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_RELEASE: begin
        // A fault on a release edge wins, so no domain can be released then dropped.
        if (fault) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          fab_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          for (int k = 0; k < N_OUT; k++) begin
            if (cnt_inc == CNT_W'(STAGE_DLY * (k + 1))) fab_nxt[k] = 1'b1;
          end
          if (cnt_inc == CNT_W'(REL_CYC)) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fault) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          fab_nxt   = '0;
        end
      end
      ST_HOLD: begin
        fab_nxt = '0;
        if (cnt_inc == CNT_W'(STAGE_DLY)) begin
          state_nxt = ST_WAIT_INIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
        fab_nxt   = '0;
      end
    endcase
  end

  assign FABRIC_RESET_N  = fab_q;
  assign PLL_POWERDOWN_B = pll_q;
  assign SEQ_DONE        = seq_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_multi_domain_reset_seq.sv
// Bench for multi_domain_reset_seq: directed scenarios followed by random input
// churn, all compared each cycle against a phase/elapsed-time reference model.
module tb_multi_domain_reset_seq;

  localparam int N_OUT       = 4;
  localparam int N_LOCK      = 2;
  localparam int STAGE_DLY   = 16;
  localparam int LOCK_FILT   = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              ext_rst_n;
  logic              init_done;
  logic              bank_ok;
  logic [N_LOCK-1:0] pll_lock;
  logic              sw_rst_req;
  logic [N_OUT-1:0]  fabric_reset_n;
  logic              pll_pd_b;
  logic              seq_done;
  logic [2:0]        state;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number, consecutive-lock run length, elapsed cycles in phase
  int m_state;
  int m_run;
  int m_el;
  logic [N_LOCK+1:0] m_hist [SYNC_STAGES];

  always #5 clk = ~clk;

  multi_domain_reset_seq #(
    .N_OUT(N_OUT), .N_LOCK(N_LOCK), .STAGE_DLY(STAGE_DLY),
    .LOCK_FILT(LOCK_FILT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(clk),
    .EXT_RST_N(ext_rst_n),
    .INIT_DONE(init_done),
    .BANK_VDDI_STATUS(bank_ok),
    .PLL_LOCK(pll_lock),
    .SW_RST_REQ(sw_rst_req),
    .FABRIC_RESET_N(fabric_reset_n),
    .PLL_POWERDOWN_B(pll_pd_b),
    .SEQ_DONE(seq_done),
    .STATE(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_el    = 0;
    for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
  endtask

  task automatic model_step();
    logic init_s, bank_s, lock_all, supply, fault;
    init_s   = m_hist[SYNC_STAGES-1][0];
    bank_s   = m_hist[SYNC_STAGES-1][1];
    lock_all = &m_hist[SYNC_STAGES-1][N_LOCK+1:2];
    for (int i = SYNC_STAGES-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = {pll_lock, bank_ok, init_done};
    supply = init_s & bank_s;
    fault  = !lock_all || !supply || sw_rst_req;
    case (m_state)
      0: m_state = 1;
      1: if (supply) begin m_state = 2; m_run = 0; end
      2: begin
        if (!supply) m_state = 1;
        else if (lock_all) begin
          m_run++;
          if (m_run == LOCK_FILT) begin m_state = 3; m_el = 0; end
        end else m_run = 0;
      end
      3: begin
        if (fault) begin m_state = 5; m_el = 0; end
        else begin
          m_el++;
          if (m_el == STAGE_DLY * N_OUT) m_state = 4;
        end
      end
      4: if (fault) begin m_state = 5; m_el = 0; end
      5: begin
        m_el++;
        if (m_el == STAGE_DLY) m_state = 1;
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [31:0] expected();
    logic [N_OUT-1:0] fab;
    case (m_state)
      3:       fab = N_OUT'((1 << (m_el / STAGE_DLY)) - 1);
      4:       fab = '1;
      default: fab = '0;
    endcase
    return 32'({3'(m_state), fab, (m_state == 4), (m_state != 0)});
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!ext_rst_n) model_reset();
    else model_step();
    #1;
    check("cycle", 32'({state, fabric_reset_n, seq_done, pll_pd_b}), expected());
  endtask

  task automatic assert_reset();
    ext_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_fab", 32'(fabric_reset_n), 0);
    check("rst_pll", 32'(pll_pd_b), 0);
    check("rst_seq", 32'(seq_done), 0);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (state == target) found = 1'b1;
    end
    check(tag, 32'(found), 1);
  endtask

  initial begin
    logic [N_OUT-1:0] steps [5];
    steps[0] = 4'b0000; steps[1] = 4'b0001; steps[2] = 4'b0011;
    steps[3] = 4'b0111; steps[4] = 4'b1111;

    ext_rst_n  = 1'b1;
    init_done  = 1'b1;
    bank_ok    = 1'b1;
    pll_lock   = '1;
    sw_rst_req = 1'b0;
    model_reset();
    #1;
    assert_reset();
    repeat (3) tick();

    // Clean power-up
    ext_rst_n = 1'b1;
    tick();
    check("pwr_wait_init", 32'(state), 1);
    check("pwr_pll_on", 32'(pll_pd_b), 1);
    wait_state(3'd3, 40, "pwr_release_entry");
    for (int k = 0; k < N_OUT; k++) begin
      repeat (STAGE_DLY - 1) tick();
      check("pwr_before_step", 32'(fabric_reset_n), 32'(steps[k]));
      tick();
      check("pwr_step", 32'(fabric_reset_n), 32'(steps[k+1]));
    end
    check("pwr_seq_done", 32'(seq_done), 1);
    check("pwr_run", 32'(state), 4);

    // Lock loss in RUN: three edges to drop resets, then 16 cycles of HOLD
    repeat (5) tick();
    pll_lock[0] = 1'b0;
    tick();
    tick();
    check("lockloss_still_run", 32'({fabric_reset_n, seq_done}), 32'b11111);
    tick();
    check("lockloss_fab", 32'(fabric_reset_n), 0);
    check("lockloss_seq", 32'(seq_done), 0);
    check("lockloss_hold", 32'(state), 5);
    pll_lock[0] = 1'b1;
    for (int i = 0; i < STAGE_DLY - 1; i++) begin
      tick();
      check("lockloss_in_hold", 32'(state), 5);
    end
    tick();
    check("lockloss_wait_init", 32'(state), 1);
    wait_state(3'd4, 200, "lockloss_rerun");

    // Soft reset in RUN
    repeat (3) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sw_fab", 32'(fabric_reset_n), 0);
    check("sw_hold", 32'(state), 5);
    check("sw_pll_on", 32'(pll_pd_b), 1);
    repeat (STAGE_DLY - 1) tick();
    check("sw_hold_end", 32'(state), 5);
    tick();
    check("sw_wait_init", 32'(state), 1);
    wait_state(3'd4, 200, "sw_reseq_run");

    // Fault coincides with the 0011->0111 release edge
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wait_state(3'd3, 100, "coinc_release_entry");
    repeat (3 * STAGE_DLY - 1) tick();
    check("coinc_pre", 32'(fabric_reset_n), 32'b0011);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("coinc_fab", 32'(fabric_reset_n), 0);
    check("coinc_hold", 32'(state), 5);

    // Lock glitch inside WAIT_LOCK clears the filter
    pll_lock = '0;
    wait_state(3'd2, 60, "glitch_wait_lock");
    repeat (4) tick();
    check("glitch_unlocked", 32'(state), 2);
    pll_lock = '1;
    repeat (5) tick();
    pll_lock[1] = 1'b0;
    tick();
    pll_lock[1] = 1'b1;
    repeat (9) tick();
    check("glitch_filter_cleared", 32'(state), 2);
    tick();
    check("glitch_release", 32'(state), 3);

    // External reset at cycle 40 of RELEASE
    repeat (40) tick();
    check("midrel_fab", 32'(fabric_reset_n), 32'b0011);
    assert_reset();
    tick();
    ext_rst_n = 1'b1;
    wait_state(3'd4, 200, "midrel_rerun");
    check("midrel_all_out", 32'(fabric_reset_n), 32'b1111);

    // Random churn on every input
    for (int c = 0; c < 4000; c++) begin
      if (init_done) init_done = ($urandom_range(0, 399) != 0);
      else init_done = ($urandom_range(0, 2) == 0);
      if (bank_ok) bank_ok = ($urandom_range(0, 399) != 0);
      else bank_ok = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < N_LOCK; b++) begin
        if (pll_lock[b]) pll_lock[b] = ($urandom_range(0, 249) != 0);
        else pll_lock[b] = ($urandom_range(0, 2) == 0);
      end
      sw_rst_req = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        assert_reset();
        tick();
        ext_rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
